score_sequencer: RTL and testbench



---
 rtl/score_pkg.sv | 32 +++
 rtl/score_sequencer_if.sv | 20 ++
 rtl/song_rom.sv | 30 +++
 rtl/score_sequencer.sv | 138 +++++++++++++
 tb/tb_score_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score sequencer
package score_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } seq_state_t;

  localparam logic [3:0] IDX_REST = 4'd0;
  localparam logic [3:0] IDX_END  = 4'd15;

  localparam int SONG_STRIDE = 64;

  // Key index 1..7 (C..B) to its bit on the note bus; anything else is silence.
  function automatic logic [7:0] key_mask(input logic [3:0] idx);
    key_mask = 8'h00;
    case (idx)
      4'd1: key_mask = 8'h01;
      4'd2: key_mask = 8'h02;
      4'd3: key_mask = 8'h04;
      4'd4: key_mask = 8'h08;
      4'd5: key_mask = 8'h10;
      4'd6: key_mask = 8'h20;
      4'd7: key_mask = 8'h40;
      default: key_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// rtl/score_sequencer_if.sv - control and note bus between player control and sequencer
interface score_sequencer_if;
  logic       start;
  logic       stop;
  logic [1:0] song_sel;
  logic [7:0] note;
  logic       playing;
  logic       done;
  logic       tick;

  modport master (
    output start, stop, song_sel,
    input  note, playing, done, tick
  );

  modport slave (
    input  start, stop, song_sel,
    output note, playing, done, tick
  );
endinterface

// File: rtl/song_rom.sv
// rtl/song_rom.sv - 256x8 song table with one-cycle registered read
module song_rom
  import score_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  // Entries are {idx, dur}. Unlisted addresses hold an end marker, except
  // song 1 which is 64 F quarter-beats with no end marker so it loops.
  always_ff @(posedge clk) begin
    case (addr)
      // song 0: C x2, end
      8'd0:   data <= 8'h12;
      8'd1:   data <= {IDX_END, 4'h0};
      // song 2: E x1, E x1, end
      8'd128: data <= 8'h31;
      8'd129: data <= 8'h31;
      8'd130: data <= {IDX_END, 4'h0};
      // song 3: rest x1, D x0 (skipped), G x1, end
      8'd192: data <= {IDX_REST, 4'h1};
      8'd193: data <= 8'h20;
      8'd194: data <= 8'h51;
      8'd195: data <= {IDX_END, 4'h0};
      default: data <= (addr[7:6] == 2'd1) ? 8'h41 : {IDX_END, 4'h0};
    endcase
  end

endmodule

// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - plays a stored song onto the one-hot note bus, tick aligned
module score_sequencer
  import score_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = 100000,
  parameter int unsigned BEAT_TICKS  = 16,
  parameter int unsigned GAP_TICKS   = 2
)
(
  input  logic              vga_clk,
  input  logic              rst,
  score_sequencer_if.slave  bus
);

  localparam logic [19:0] TICK_LAST = 20'(TICK_PERIOD - 1);
  localparam logic [7:0]  BEAT_W    = 8'(BEAT_TICKS);
  localparam logic [7:0]  GAP_W     = 8'(GAP_TICKS);

  logic [19:0] tick_cnt;
  logic        tick;

  seq_state_t  state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [5:0]  offset_q, offset_d;
  logic [7:0]  rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  note_q, note_d;

  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_idx;
  logic [3:0]  rom_dur;

  // Offset is 6 bits, so the address wraps inside the 64-entry song window.
  assign rom_addr = base_q + {2'b00, offset_q};
  assign rom_idx  = rom_data[7:4];
  assign rom_dur  = rom_data[3:0];

  song_rom u_rom (
    .clk  (vga_clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Free-running tick counter, matched to the display scroll period.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 20'd1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // State and datapath registers.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      offset_q <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
    end
  end

  // Next-state and datapath updates; stop overrides everything, including start.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    offset_d = offset_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    note_d   = note_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          base_d   = 8'(int'(bus.song_sel) * SONG_STRIDE);
          offset_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (rom_idx == IDX_END) begin
          note_d  = 8'h00;
          state_d = S_DONE;
        end else if (rom_dur == 4'd0) begin
          offset_d = offset_q + 6'd1;
          state_d  = S_FETCH;
        end else begin
          rem_d   = {4'h0, rom_dur} * BEAT_W;
          idx_d   = rom_idx;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          // The last GAP_TICKS ticks of every note are silent.
          note_d = (rem_q > GAP_W) ? key_mask(idx_q) : 8'h00;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            offset_d = offset_q + 6'd1;
            state_d  = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        note_d  = 8'h00;
      end
    endcase

    if (bus.stop) begin
      state_d = S_IDLE;
      note_d  = 8'h00;
    end
  end

  assign bus.note    = note_q;
  assign bus.tick    = tick;
  assign bus.done    = (state_q == S_DONE);
  assign bus.playing = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);

endmodule

// File: tb/tb_score_sequencer.sv
// tb/tb_score_sequencer.sv - directed self-checking bench for score_sequencer
module tb_score_sequencer;

  localparam int TP = 4;
  localparam int BT = 4;
  localparam int GT = 1;

  logic vga_clk = 1'b0;
  logic rst     = 1'b1;

  int errors = 0;
  int checks = 0;

  score_sequencer_if sif();

  score_sequencer #(
    .TICK_PERIOD (TP),
    .BEAT_TICKS  (BT),
    .GAP_TICKS   (GT)
  ) dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (sif)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Advance past the next clock edge at which tick is high (bounded).
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * TP && !ok; i++) begin
      if (sif.tick) ok = 1'b1;
      step();
    end
  endtask

  // Pulse start and advance through FETCH and LOAD.
  task automatic start_song(input logic [1:0] s);
    sif.song_sel = s;
    sif.start    = 1'b1;
    step();
    sif.start    = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    sif.start = 1'b0; sif.stop = 1'b0; sif.song_sel = 2'd0;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (sif.note !== 8'h00) begin errors++; $display("FAIL reset_note: got %h expected 00", sif.note); end
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b expected 0", sif.playing); end
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", sif.done); end
    checks++; if (sif.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", sif.tick); end
    rst = 1'b0;
    repeat (2) step();
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL idle_playing: got %b expected 0", sif.playing); end
  endtask

  task automatic test_single_note();
    bit ok;
    logic [7:0] exp;
    start_song(2'd0);
    checks++; if (sif.playing !== 1'b1) begin errors++; $display("FAIL single_playing: got %b expected 1", sif.playing); end
    for (int t = 0; t < 8; t++) begin
      wait_tick(ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_tick_timeout: got no tick at tick %0d expected tick", t); end
      exp = (t < 7) ? 8'h01 : 8'h00;
      checks++; if (sif.note !== exp) begin errors++; $display("FAIL single_note: tick %0d got %h expected %h", t, sif.note, exp); end
    end
    step(); step();
    checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", sif.done); end
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL single_end_playing: got %b expected 0", sif.playing); end
    checks++; if (sif.note !== 8'h00) begin errors++; $display("FAIL single_end_note: got %h expected 00", sif.note); end
    repeat (6) step();
    checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL single_done_hold: got %b expected 1", sif.done); end
  endtask

  task automatic test_repeated();
    logic [7:0] prev_note;
    logic       prev_tick;
    logic [7:0] exp;
    int         nt;
    start_song(2'd2);
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL rep_done_cleared: got %b expected 0", sif.done); end
    prev_note = sif.note;
    prev_tick = sif.tick;
    nt = 0;
    for (int c = 0; c < 80 && nt < 8; c++) begin
      step();
      if (!prev_tick) begin
        checks++;
        if (sif.note !== prev_note) begin errors++; $display("FAIL rep_off_tick_change: cycle %0d got %h expected %h", c, sif.note, prev_note); end
      end else begin
        exp = (nt % 4 == 3) ? 8'h00 : 8'h04;
        checks++; if (sif.note !== exp) begin errors++; $display("FAIL rep_note: tick %0d got %h expected %h", nt, sif.note, exp); end
        nt++;
      end
      prev_note = sif.note;
      prev_tick = sif.tick;
    end
    checks++; if (nt != 8) begin errors++; $display("FAIL rep_tick_count: got %0d expected 8", nt); end
    step(); step();
    checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL rep_done: got %b expected 1", sif.done); end
  endtask

  task automatic test_rest_skip();
    bit ok;
    bit found;
    bit seen_d;
    int zeros;
    start_song(2'd3);
    found = 1'b0; seen_d = 1'b0; zeros = 0;
    for (int t = 0; t < 12 && !found; t++) begin
      wait_tick(ok);
      if (sif.note === 8'h02) seen_d = 1'b1;
      if (sif.note !== 8'h00) found = 1'b1;
      else zeros++;
    end
    checks++; if (!found) begin errors++; $display("FAIL rest_no_key: got none expected 10"); end
    // The rest gives 4 silent ticks; the skipped D entry can swallow one more.
    checks++; if (zeros < 4 || zeros > 5) begin errors++; $display("FAIL rest_zero_ticks: got %0d expected 4..5", zeros); end
    checks++; if (sif.note !== 8'h10) begin errors++; $display("FAIL rest_first_g: got %h expected 10", sif.note); end
    for (int t = 0; t < 3; t++) begin
      wait_tick(ok);
      if (sif.note === 8'h02) seen_d = 1'b1;
      checks++;
      if (sif.note !== ((t < 2) ? 8'h10 : 8'h00)) begin errors++; $display("FAIL rest_g_note: tick %0d got %h expected %h", t, sif.note, (t < 2) ? 8'h10 : 8'h00); end
    end
    checks++; if (seen_d) begin errors++; $display("FAIL rest_d_seen: got 1 expected 0"); end
    step(); step();
    checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL rest_done: got %b expected 1", sif.done); end
  endtask

  task automatic test_stop();
    bit ok;
    start_song(2'd0);
    wait_tick(ok);
    checks++; if (sif.note !== 8'h01) begin errors++; $display("FAIL stop_pre_note: got %h expected 01", sif.note); end
    step();
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    checks++; if (sif.note !== 8'h00) begin errors++; $display("FAIL stop_note: got %h expected 00", sif.note); end
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL stop_playing: got %b expected 0", sif.playing); end
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL stop_done: got %b expected 0", sif.done); end

    sif.song_sel = 2'd0; sif.start = 1'b1; sif.stop = 1'b1;
    step();
    sif.start = 1'b0; sif.stop = 1'b0;
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL startstop_playing: got %b expected 0", sif.playing); end
    repeat (3) step();
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL startstop_idle: got %b expected 0", sif.playing); end

    start_song(2'd0);
    wait_tick(ok);
    checks++; if (sif.note !== 8'h01) begin errors++; $display("FAIL restart_note: got %h expected 01", sif.note); end
    sif.song_sel = 2'd2; sif.start = 1'b1;
    step();
    sif.start = 1'b0;
    checks++; if (sif.playing !== 1'b1) begin errors++; $display("FAIL ignore_start_playing: got %b expected 1", sif.playing); end
    wait_tick(ok);
    checks++; if (sif.note !== 8'h01) begin errors++; $display("FAIL ignore_start_note: got %h expected 01", sif.note); end
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_song(2'd2);
    wait_tick(ok);
    checks++; if (sif.note !== 8'h04) begin errors++; $display("FAIL rstmid_pre_note: got %h expected 04", sif.note); end
    rst = 1'b1;
    step();
    checks++; if (sif.note !== 8'h00) begin errors++; $display("FAIL rstmid_note: got %h expected 00", sif.note); end
    checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL rstmid_playing: got %b expected 0", sif.playing); end
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", sif.done); end
    checks++; if (sif.tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick: got %b expected 0", sif.tick); end
    step(); step();
    rst = 1'b0;
    repeat (6) step();
    checks++; if (sif.playing !== 1'b0 || sif.note !== 8'h00) begin errors++; $display("FAIL rstmid_after: got playing=%b note=%h expected 0/00", sif.playing, sif.note); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] exp;
    start_song(2'd1);
    for (int e = 0; e < 66; e++) begin
      for (int k = 0; k < 4; k++) begin
        wait_tick(ok);
        exp = (k == 3) ? 8'h00 : 8'h08;
        checks++; if (!ok || sif.note !== exp) begin errors++; $display("FAIL wrap_note: entry %0d tick %0d got %h expected %h", e, k, sif.note, exp); end
      end
    end
    checks++; if (sif.playing !== 1'b1 || sif.done !== 1'b0) begin errors++; $display("FAIL wrap_state: got playing=%b done=%b expected 1/0", sif.playing, sif.done); end
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_repeated();
    test_rest_skip();
    test_stop();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
